// File: rtl/bpu_btb.sv
// bpu_btb: direct-mapped, tagged branch target buffer with per-entry 2-bit
// saturating counters and a hardware invalidate sweep.
//
// Ports
//   clk              clock, all state updates on the rising edge
//   rst              asynchronous active-high reset (starts an invalidate sweep)
//   pc_addr_i        IF-stage PC to look up
//   pr_o/pr_addr_o   prediction taken / predicted target (0 when not taken)
//   upd_valid_i      a branch resolved this cycle
//   upd_addr_i       PC of the resolved branch
//   upd_taken_i      actual direction
//   upd_target_i     actual taken target
//   upd_pred_i       prediction carried with the branch
//   upd_pred_addr_i  predicted target carried with the branch
//   br_o/br_addr_o   mispredict redirect / redirect address
//   flush_i          invalidate the whole table
//   busy_o           invalidate sweep in progress
module bpu_btb #(
    parameter int unsigned ENTRIES  = 256,
    parameter int unsigned TAG_W    = 8,
    parameter int unsigned ADDR_W   = 32,
    parameter logic [1:0]  CNT_INIT = 2'b10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_addr_i,
    output logic              pr_o,
    output logic [ADDR_W-1:0] pr_addr_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_addr_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_pred_i,
    input  logic [ADDR_W-1:0] upd_pred_addr_i,
    output logic              br_o,
    output logic [ADDR_W-1:0] br_addr_o,
    input  logic              flush_i,
    output logic              busy_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic {INIT, READY} state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;

    logic              valid_mem  [ENTRIES];
    logic [TAG_W-1:0]  tag_mem    [ENTRIES];
    logic [ADDR_W-1:0] target_mem [ENTRIES];
    logic [1:0]        cnt_mem    [ENTRIES];

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              lk_hit;
    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic              up_hit;
    logic [1:0]        up_cnt;
    logic              train;

    // Bits of the lookup PC outside index/tag take no part in the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_addr_i[ADDR_W-1:IDX_W+TAG_W+2], pc_addr_i[1:0]};

    assign lk_idx = pc_addr_i[IDX_W+1:2];
    assign lk_tag = pc_addr_i[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = upd_addr_i[IDX_W+1:2];
    assign up_tag = upd_addr_i[IDX_W+TAG_W+1:IDX_W+2];

    assign busy_o = (state == INIT);

    // Lookup: reads the stored contents, so a same-cycle write is not seen.
    always_comb begin
        lk_hit    = valid_mem[lk_idx] && (tag_mem[lk_idx] == lk_tag);
        pr_o      = lk_hit && cnt_mem[lk_idx][1] && !busy_o;
        pr_addr_o = pr_o ? target_mem[lk_idx] : '0;
    end

    // Redirect is independent of the table state, so it stays live during a sweep.
    always_comb begin
        br_o      = 1'b0;
        br_addr_o = '0;
        if (upd_valid_i && !rst) begin
            if (upd_taken_i && (!upd_pred_i || (upd_pred_addr_i != upd_target_i))) begin
                br_o      = 1'b1;
                br_addr_o = upd_target_i;
            end else if (!upd_taken_i && upd_pred_i) begin
                br_o      = 1'b1;
                br_addr_o = upd_addr_i + ADDR_W'(4);
            end
        end
    end

    always_comb begin
        up_hit = valid_mem[up_idx] && (tag_mem[up_idx] == up_tag);
        up_cnt = cnt_mem[up_idx];
        train  = (state == READY) && upd_valid_i && !flush_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (flush_i) begin
                        ptr <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                        if (ptr == LAST_IDX) begin
                            state <= READY;
                        end
                    end
                end
                READY: begin
                    if (flush_i) begin
                        state <= INIT;
                        ptr   <= '0;
                    end
                end
                default: begin
                    state <= INIT;
                    ptr   <= '0;
                end
            endcase
        end
    end

    // Table storage has no reset; the sweep that follows every reset clears valid.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            if (!flush_i) begin
                valid_mem[ptr] <= 1'b0;
            end
        end else if (train) begin
            if (up_hit) begin
                if (upd_taken_i) begin
                    cnt_mem[up_idx]    <= (up_cnt == 2'b11) ? 2'b11 : up_cnt + 2'b01;
                    target_mem[up_idx] <= upd_target_i;
                end else begin
                    cnt_mem[up_idx]    <= (up_cnt == 2'b00) ? 2'b00 : up_cnt - 2'b01;
                end
            end else if (upd_taken_i) begin
                valid_mem[up_idx]  <= 1'b1;
                tag_mem[up_idx]    <= up_tag;
                target_mem[up_idx] <= upd_target_i;
                cnt_mem[up_idx]    <= CNT_INIT;
            end
        end
    end

endmodule

// File: tb/tb_bpu_btb.sv
module tb_bpu_btb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_addr_i;
    logic        pr_o;
    logic [31:0] pr_addr_o;
    logic        upd_valid_i;
    logic [31:0] upd_addr_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_pred_i;
    logic [31:0] upd_pred_addr_i;
    logic        br_o;
    logic [31:0] br_addr_o;
    logic        flush_i;
    logic        busy_o;

    int n_vec = 0;
    int n_err = 0;

    bpu_btb #(
        .ENTRIES (256),
        .TAG_W   (8),
        .ADDR_W  (32),
        .CNT_INIT(2'b10)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_addr_i      (pc_addr_i),
        .pr_o           (pr_o),
        .pr_addr_o      (pr_addr_o),
        .upd_valid_i    (upd_valid_i),
        .upd_addr_i     (upd_addr_i),
        .upd_taken_i    (upd_taken_i),
        .upd_target_i   (upd_target_i),
        .upd_pred_i     (upd_pred_i),
        .upd_pred_addr_i(upd_pred_addr_i),
        .br_o           (br_o),
        .br_addr_o      (br_addr_o),
        .flush_i        (flush_i),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        uv;
        logic [31:0] ua;
        logic        tk;
        logic [31:0] tg;
        logic        pd;
        logic [31:0] pa;
        logic        fl;
        logic        e_pr;
        logic [31:0] e_pa;
        logic        e_br;
        logic [31:0] e_ba;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] pc, input logic uv, input logic [31:0] ua,
                       input logic tk, input logic [31:0] tg, input logic pd,
                       input logic [31:0] pa, input logic fl, input logic e_pr,
                       input logic [31:0] e_pa, input logic e_br, input logic [31:0] e_ba,
                       input logic e_busy);
        vec_t v;
        v.pc = pc; v.uv = uv; v.ua = ua; v.tk = tk; v.tg = tg; v.pd = pd; v.pa = pa;
        v.fl = fl; v.e_pr = e_pr; v.e_pa = e_pa; v.e_br = e_br; v.e_ba = e_ba;
        v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        upd_valid_i = 1'b0; upd_addr_i = '0; upd_taken_i = 1'b0; upd_target_i = '0;
        upd_pred_i = 1'b0; upd_pred_addr_i = '0; flush_i = 1'b0;
    endtask

    // Counts rising edges until busy_o drops, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy_o && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    int n;

    initial begin
        rst = 1'b1;
        pc_addr_i = 32'h100;
        idle_inputs();

        // Reset state, with an update driven that would otherwise redirect
        upd_valid_i = 1'b1; upd_taken_i = 1'b1; upd_target_i = 32'h40;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd1);
        chk("rst_pr", 32'(pr_o), 32'd0);
        chk("rst_pr_addr", pr_addr_o, 32'h0);
        chk("rst_br", 32'(br_o), 32'd0);
        chk("rst_br_addr", br_addr_o, 32'h0);
        idle_inputs();
        rst = 1'b0;
        count_busy(n);
        chk("init_sweep_len", 32'(n), 32'd256);
        for (int i = 0; i < 6; i++) begin
            pc_addr_i = 32'h100 * i + 32'h1004;
            @(negedge clk);
            chk("empty_pr", 32'(pr_o), 32'd0);
        end
        @(posedge clk); #1;

        //   pc      uv  ua            tk  tg        pd  pa       fl  pr  pa       br  ba            busy
        add(32'h100, 1, 32'h100,       1, 32'h40,   0, 32'h0,    0,  0, 32'h0,    1, 32'h40,       0);
        add(32'h100, 0, 32'h0,         0, 32'h0,    0, 32'h0,    0,  1, 32'h40,   0, 32'h0,        0);
        add(32'h500, 0, 32'h0,         0, 32'h0,    0, 32'h0,    0,  0, 32'h0,    0, 32'h0,        0);
        add(32'h500, 1, 32'h500,       1, 32'h80,   0, 32'h0,    0,  0, 32'h0,    1, 32'h80,       0);
        add(32'h100, 0, 32'h0,         0, 32'h0,    0, 32'h0,    0,  0, 32'h0,    0, 32'h0,        0);
        add(32'h500, 0, 32'h0,         0, 32'h0,    0, 32'h0,    0,  1, 32'h80,   0, 32'h0,        0);
        // re-allocate 0x100 (cnt=10), then walk the counter
        add(32'h100, 1, 32'h100,       1, 32'h40,   0, 32'h0,    0,  0, 32'h0,    1, 32'h40,       0);
        add(32'h100, 1, 32'h100,       0, 32'h0,    1, 32'h40,   0,  1, 32'h40,   1, 32'h104,      0);
        add(32'h100, 0, 32'h0,         0, 32'h0,    0, 32'h0,    0,  0, 32'h0,    0, 32'h0,        0);
        add(32'h100, 1, 32'h100,       1, 32'h40,   0, 32'h0,    0,  0, 32'h0,    1, 32'h40,       0);
        add(32'h100, 1, 32'h100,       1, 32'h40,   1, 32'h40,   0,  1, 32'h40,   0, 32'h0,        0);
        add(32'h100, 1, 32'h100,       1, 32'h40,   1, 32'h40,   0,  1, 32'h40,   0, 32'h0,        0);
        add(32'h100, 0, 32'h0,         0, 32'h0,    0, 32'h0,    0,  1, 32'h40,   0, 32'h0,        0);
        add(32'h100, 1, 32'h100,       0, 32'h0,    1, 32'h40,   0,  1, 32'h40,   1, 32'h104,      0);
        add(32'h100, 0, 32'h0,         0, 32'h0,    0, 32'h0,    0,  1, 32'h40,   0, 32'h0,        0);
        add(32'h100, 1, 32'h100,       0, 32'h0,    1, 32'h40,   0,  1, 32'h40,   1, 32'h104,      0);
        add(32'h100, 0, 32'h0,         0, 32'h0,    0, 32'h0,    0,  0, 32'h0,    0, 32'h0,        0);
        // target change
        add(32'h100, 1, 32'h100,       1, 32'h40,   0, 32'h0,    0,  0, 32'h0,    1, 32'h40,       0);
        add(32'h100, 1, 32'h100,       1, 32'h60,   1, 32'h40,   0,  1, 32'h40,   1, 32'h60,       0);
        add(32'h100, 0, 32'h0,         0, 32'h0,    0, 32'h0,    0,  1, 32'h60,   0, 32'h0,        0);
        // miss not taken: no allocation
        add(32'h200, 1, 32'h200,       0, 32'h0,    0, 32'h0,    0,  0, 32'h0,    0, 32'h0,        0);
        add(32'h200, 0, 32'h0,         0, 32'h0,    0, 32'h0,    0,  0, 32'h0,    0, 32'h0,        0);
        // fall-through address wraps
        add(32'h100, 1, 32'hFFFFFFFE,  0, 32'h0,    1, 32'h0,    0,  1, 32'h60,   1, 32'h2,        0);
        // low PC bits ignored
        add(32'h103, 0, 32'h0,         0, 32'h0,    0, 32'h0,    0,  1, 32'h60,   0, 32'h0,        0);
        // no redirect without upd_valid_i
        add(32'h100, 0, 32'h300,       1, 32'h999,  0, 32'h0,    0,  1, 32'h60,   0, 32'h0,        0);
        // flush with simultaneous taken update: redirect still produced
        add(32'h300, 1, 32'h300,       1, 32'h70,   0, 32'h0,    1,  0, 32'h0,    1, 32'h70,       0);
        add(32'h100, 0, 32'h0,         0, 32'h0,    0, 32'h0,    0,  0, 32'h0,    0, 32'h0,        1);

        foreach (vecs[i]) begin
            pc_addr_i = vecs[i].pc; upd_valid_i = vecs[i].uv; upd_addr_i = vecs[i].ua;
            upd_taken_i = vecs[i].tk; upd_target_i = vecs[i].tg; upd_pred_i = vecs[i].pd;
            upd_pred_addr_i = vecs[i].pa; flush_i = vecs[i].fl;
            @(negedge clk);
            chk($sformatf("v%0d_pr", i), 32'(pr_o), 32'(vecs[i].e_pr));
            chk($sformatf("v%0d_pr_addr", i), pr_addr_o, vecs[i].e_pa);
            chk($sformatf("v%0d_br", i), 32'(br_o), 32'(vecs[i].e_br));
            chk($sformatf("v%0d_br_addr", i), br_addr_o, vecs[i].e_ba);
            chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'(vecs[i].e_busy));
            @(posedge clk); #1;
        end
        idle_inputs();

        // Flush sweep: one edge already consumed by the last vector
        count_busy(n);
        chk("flush_sweep_len", 32'(n + 1), 32'd256);
        pc_addr_i = 32'h300;
        @(negedge clk);
        chk("flush_no_alloc", 32'(pr_o), 32'd0);
        pc_addr_i = 32'h100;
        @(negedge clk);
        chk("flush_cleared", 32'(pr_o), 32'd0);
        pc_addr_i = 32'h500;
        @(negedge clk);
        chk("flush_cleared2", 32'(pr_o), 32'd0);

        // Flush during a sweep restarts it
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        count_busy(n);
        chk("reflush_sweep_len", 32'(n), 32'd256);

        // Reset at sweep cycle 100 restarts the sweep
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        upd_valid_i = 1'b1; upd_addr_i = 32'h100; upd_pred_i = 1'b1; upd_taken_i = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy_o), 32'd1);
        chk("midrst_br", 32'(br_o), 32'd0);
        chk("midrst_br_addr", br_addr_o, 32'h0);
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b0;
        count_busy(n);
        chk("midrst_sweep_len", 32'(n), 32'd256);
        @(negedge clk);
        chk("after_sweep_busy", 32'(busy_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
